// File: rtl/axi_stream_master_packetizer.sv
// axi_stream_master_packetizer: registered AXI-Stream master with a two-entry
// (output + skid) buffer, beat counting with forced tlast every pkt_len beats,
// and a count of completed packets.
// Optional build macro AXIS_TX_FORMAL_EN enables embedded protocol assertions.
module axi_stream_master_packetizer #(
  parameter int unsigned byte_width = 4,
  parameter int unsigned pkt_len    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*byte_width-1:0]   in_data,
  input  logic [byte_width-1:0]     in_keep,
  input  logic                      in_last,
  output logic                      tvalid,
  input  logic                      tready,
  output logic [8*byte_width-1:0]   tdata,
  output logic [byte_width-1:0]     tkeep,
  output logic [byte_width-1:0]     tstrb,
  output logic                      tlast,
  output logic [15:0]               pkt_count
);

  localparam int unsigned data_w = 8 * byte_width;
  localparam int unsigned cnt_w  = (pkt_len > 1) ? $clog2(pkt_len) : 1;
  localparam logic [cnt_w-1:0] last_pos = cnt_w'(pkt_len - 1);

  // Output register entry
  logic              out_valid, out_valid_nxt;
  logic [data_w-1:0] out_data,  out_data_nxt;
  logic [byte_width-1:0] out_keep, out_keep_nxt;
  logic              out_last,  out_last_nxt;

  // Skid register entry
  logic              skid_valid, skid_valid_nxt;
  logic [data_w-1:0] skid_data,  skid_data_nxt;
  logic [byte_width-1:0] skid_keep, skid_keep_nxt;
  logic              skid_last,  skid_last_nxt;

  logic              ready_q, ready_nxt;
  logic [cnt_w-1:0]  acc_cnt, acc_cnt_nxt;   // packet position of the next accepted beat
  logic [cnt_w-1:0]  beat_cnt, beat_cnt_nxt; // packet position of the next transferred beat
  logic [15:0]       pkt_cnt, pkt_cnt_nxt;

  logic accept;
  logic xfer;
  logic in_last_eff;

  // Next-state computation for buffer, counters and registered in_ready
  always_comb begin
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    out_keep_nxt   = out_keep;
    out_last_nxt   = out_last;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    skid_keep_nxt  = skid_keep;
    skid_last_nxt  = skid_last;
    acc_cnt_nxt    = acc_cnt;
    beat_cnt_nxt   = beat_cnt;
    pkt_cnt_nxt    = pkt_cnt;

    accept      = in_valid && ready_q;
    xfer        = out_valid && tready;
    in_last_eff = in_last || (acc_cnt == last_pos);

    // tlast is fixed at acceptance so it cannot change while stalled
    if (accept) begin
      acc_cnt_nxt = in_last_eff ? '0 : acc_cnt + cnt_w'(1);
    end

    if (xfer) begin
      if (skid_valid) begin
        out_data_nxt   = skid_data;
        out_keep_nxt   = skid_keep;
        out_last_nxt   = skid_last;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        out_data_nxt = in_data;
        out_keep_nxt = in_keep;
        out_last_nxt = in_last_eff;
      end else begin
        out_valid_nxt = 1'b0;
      end
      beat_cnt_nxt = out_last ? '0 : beat_cnt + cnt_w'(1);
      if (out_last) begin
        pkt_cnt_nxt = pkt_cnt + 16'd1;
      end
    end else if (accept) begin
      if (!out_valid) begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = in_data;
        out_keep_nxt  = in_keep;
        out_last_nxt  = in_last_eff;
      end else begin
        skid_valid_nxt = 1'b1;
        skid_data_nxt  = in_data;
        skid_keep_nxt  = in_keep;
        skid_last_nxt  = in_last_eff;
      end
    end

    // in_ready comes from a flop: open whenever the skid entry will be free
    ready_nxt = !skid_valid_nxt;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
      ready_q    <= 1'b0;
      acc_cnt    <= '0;
      beat_cnt   <= '0;
      pkt_cnt    <= '0;
    end else begin
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_keep   <= out_keep_nxt;
      out_last   <= out_last_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      skid_keep  <= skid_keep_nxt;
      skid_last  <= skid_last_nxt;
      ready_q    <= ready_nxt;
      acc_cnt    <= acc_cnt_nxt;
      beat_cnt   <= beat_cnt_nxt;
      pkt_cnt    <= pkt_cnt_nxt;
    end
  end

  assign in_ready  = ready_q;
  assign tvalid    = out_valid;
  assign tdata     = out_data;
  assign tkeep     = out_keep;
  assign tstrb     = out_keep;
  assign tlast     = out_last;
  assign pkt_count = pkt_cnt;

`ifdef AXIS_TX_FORMAL_EN
  logic                  f_prev_reset;
  logic                  f_prev_stall;
  logic [data_w-1:0]     f_prev_data;
  logic [byte_width-1:0] f_prev_keep;
  logic                  f_prev_last;

  // Capture previous-cycle state for stability checks
  always_ff @(posedge clk) begin
    f_prev_reset <= reset;
    f_prev_stall <= tvalid && !tready && !reset;
    f_prev_data  <= tdata;
    f_prev_keep  <= tkeep;
    f_prev_last  <= tlast;
  end

  // Protocol properties of the master interface
  always_ff @(posedge clk) begin
    if (f_prev_stall) begin
      assert (tvalid);
      assert (tdata == f_prev_data);
      assert (tkeep == f_prev_keep);
      assert (tlast == f_prev_last);
    end
    if (f_prev_reset) begin
      assert (!tvalid);
    end
    assert (tstrb == tkeep);
    assert (32'(beat_cnt) < pkt_len);
  end
`else
  // No embedded checks in the default build
`endif

endmodule

// File: tb/tb_axi_stream_master_packetizer.sv
// Directed bench for axi_stream_master_packetizer with scoreboard checking.
// Instance a uses pkt_len=4, instance b uses pkt_len=16.
module tb_axi_stream_master_packetizer;

  localparam int unsigned bw    = 4;
  localparam int unsigned dw    = 8 * bw;
  localparam int unsigned len_a = 4;
  localparam int unsigned len_b = 16;

  typedef struct packed {
    logic [dw-1:0] data;
    logic [bw-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_in_last, a_tvalid, a_tready, a_tlast;
  logic [dw-1:0] a_in_data, a_tdata;
  logic [bw-1:0] a_in_keep, a_tkeep, a_tstrb;
  logic [15:0]   a_pkt_count;

  logic          b_in_valid, b_in_ready, b_in_last, b_tvalid, b_tready, b_tlast;
  logic [dw-1:0] b_in_data, b_tdata;
  logic [bw-1:0] b_in_keep, b_tkeep, b_tstrb;
  logic [15:0]   b_pkt_count;

  axi_stream_master_packetizer #(.byte_width(bw), .pkt_len(len_a)) u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_keep(a_in_keep), .in_last(a_in_last),
    .tvalid(a_tvalid), .tready(a_tready), .tdata(a_tdata), .tkeep(a_tkeep),
    .tstrb(a_tstrb), .tlast(a_tlast), .pkt_count(a_pkt_count)
  );

  axi_stream_master_packetizer #(.byte_width(bw), .pkt_len(len_b)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_keep(b_in_keep), .in_last(b_in_last),
    .tvalid(b_tvalid), .tready(b_tready), .tdata(b_tdata), .tkeep(b_tkeep),
    .tstrb(b_tstrb), .tlast(b_tlast), .pkt_count(b_pkt_count)
  );

  int checks = 0;
  int errors = 0;

  beat_t qa[$];
  beat_t qb[$];
  int    pos_a = 0;
  int    pos_b = 0;
  beat_t ea, eb;

  logic          b_stall = 1'b0;
  logic [dw-1:0] b_hold_data;
  logic [bw-1:0] b_hold_keep;
  logic          b_hold_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beats carry the tlast implied by their packet position
  task automatic push_a(input logic [dw-1:0] d, input logic [bw-1:0] k, input logic l);
    beat_t e;
    e.data = d;
    e.keep = k;
    e.last = l || (pos_a == int'(len_a) - 1);
    pos_a  = e.last ? 0 : pos_a + 1;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [dw-1:0] d, input logic [bw-1:0] k, input logic l);
    beat_t e;
    e.data = d;
    e.keep = k;
    e.last = l || (pos_b == int'(len_b) - 1);
    pos_b  = e.last ? 0 : pos_b + 1;
    qb.push_back(e);
  endtask

  // Offer one beat to instance b, waiting a bounded time for in_ready
  task automatic send_b(input logic [dw-1:0] d, input logic [bw-1:0] k, input logic l);
    int n;
    n = 0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_keep  = k;
    b_in_last  = l;
    while (!b_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b_accept", 64'(b_in_ready), 64'd1);
    if (b_in_ready) push_b(d, k, l);
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic drain_b();
    int n;
    n = 0;
    while (qb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("b_drain", 64'(qb.size()), 64'd0);
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("a_drain", 64'(qa.size()), 64'd0);
  endtask

  // Monitor b: scoreboard on each transfer plus stability under stall
  always begin
    @(negedge clk);
    #2;
    if (!reset && b_tvalid && b_tready) begin
      if (qb.size() == 0) begin
        check("b_unexpected_beat", 64'(b_tvalid), 64'd0);
      end else begin
        eb = qb.pop_front();
        check("b_tdata", 64'(b_tdata), 64'(eb.data));
        check("b_tkeep", 64'(b_tkeep), 64'(eb.keep));
        check("b_tstrb", 64'(b_tstrb), 64'(eb.keep));
        check("b_tlast", 64'(b_tlast), 64'(eb.last));
      end
    end
    if (!reset && b_stall) begin
      check("b_hold_tvalid", 64'(b_tvalid), 64'd1);
      check("b_hold_tdata", 64'(b_tdata), 64'(b_hold_data));
      check("b_hold_tkeep", 64'(b_tkeep), 64'(b_hold_keep));
      check("b_hold_tlast", 64'(b_tlast), 64'(b_hold_last));
    end
    b_stall     = !reset && b_tvalid && !b_tready;
    b_hold_data = b_tdata;
    b_hold_keep = b_tkeep;
    b_hold_last = b_tlast;
  end

  // Monitor a: scoreboard on each transfer
  always begin
    @(negedge clk);
    #2;
    if (!reset && a_tvalid && a_tready) begin
      if (qa.size() == 0) begin
        check("a_unexpected_beat", 64'(a_tvalid), 64'd0);
      end else begin
        ea = qa.pop_front();
        check("a_tdata", 64'(a_tdata), 64'(ea.data));
        check("a_tstrb", 64'(a_tstrb), 64'(ea.keep));
        check("a_tlast", 64'(a_tlast), 64'(ea.last));
      end
    end
  end

  // Watchdog
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [dw-1:0] d;
    int sent;
    int cyc;

    reset      = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_keep = '0; a_in_last = 1'b0; a_tready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_keep = '0; b_in_last = 1'b0; b_tready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(b_tvalid), 64'd0);
    check("rst_in_ready", 64'(b_in_ready), 64'd0);
    check("rst_tdata", 64'(b_tdata), 64'd0);
    check("rst_tkeep", 64'(b_tkeep), 64'd0);
    check("rst_tstrb", 64'(b_tstrb), 64'd0);
    check("rst_tlast", 64'(b_tlast), 64'd0);
    check("rst_pkt_count", 64'(b_pkt_count), 64'd0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(b_in_ready), 64'd1);
    check("post_rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("post_rst_tvalid", 64'(b_tvalid), 64'd0);

    // First beat: latency one cycle
    b_tready = 1'b1;
    send_b(32'h1122_3344, 4'hF, 1'b0);
    check("first_tvalid", 64'(b_tvalid), 64'd1);
    check("first_tdata", 64'(b_tdata), 64'h1122_3344);
    check("first_tstrb", 64'(b_tstrb), 64'hF);
    check("first_tlast", 64'(b_tlast), 64'd0);

    // Null beat then early end-of-packet on beat 2
    send_b(32'hA5A5_0001, 4'h0, 1'b0);
    send_b(32'hA5A5_0002, 4'h3, 1'b1);
    drain_b();
    check("early_last_pkt_count", 64'(b_pkt_count), 64'd1);

    // Full packet: forced tlast on beat 15 proves the counter restarted
    for (int i = 0; i < 16; i++) send_b(32'hB000_0000 + 32'(i), 4'hF, 1'b0);
    drain_b();
    check("forced_last_pkt_count", 64'(b_pkt_count), 64'd2);

    // Stall for five cycles with input continuously offered
    b_tready   = 1'b0;
    b_in_valid = 1'b1;
    b_in_keep  = 4'hF;
    b_in_last  = 1'b0;
    d = 32'hC000_0000;
    for (int c = 0; c < 5; c++) begin
      b_in_data = d;
      check("stall_in_ready", 64'(b_in_ready), (c < 2) ? 64'd1 : 64'd0);
      if (b_in_ready) begin
        push_b(d, 4'hF, 1'b0);
        d = d + 32'd1;
      end
      @(negedge clk);
      check("stall_tvalid", 64'(b_tvalid), 64'd1);
      check("stall_tdata", 64'(b_tdata), 64'hC000_0000);
      check("stall_tlast", 64'(b_tlast), 64'd0);
    end
    check("stall_skid_full", 64'(b_in_ready), 64'd0);
    b_in_data = d;
    b_tready  = 1'b1;
    @(negedge clk);
    check("release_in_ready", 64'(b_in_ready), 64'd1);
    send_b(d, 4'hF, 1'b0);
    send_b(d + 32'd1, 4'hF, 1'b1);
    drain_b();
    check("stall_pkt_count", 64'(b_pkt_count), 64'd3);

    // Reset with two beats buffered mid-packet
    b_tready = 1'b0;
    send_b(32'hD000_0000, 4'hF, 1'b0);
    send_b(32'hD000_0001, 4'hF, 1'b0);
    check("buffered_tvalid", 64'(b_tvalid), 64'd1);
    check("buffered_in_ready", 64'(b_in_ready), 64'd0);
    reset = 1'b1;
    qb.delete();
    pos_b = 0;
    @(negedge clk);
    check("midrst_tvalid", 64'(b_tvalid), 64'd0);
    check("midrst_pkt_count", 64'(b_pkt_count), 64'd0);
    b_tready = 1'b1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(b_tvalid), 64'd0);
    end
    for (int i = 0; i < 16; i++) send_b(32'hE000_0000 + 32'(i), 4'hF, 1'b0);
    drain_b();
    check("midrst_next_pkt_count", 64'(b_pkt_count), 64'd1);

    // Instance a: eight back-to-back beats with pkt_len 4
    a_tready  = 1'b1;
    a_in_keep = 4'hF;
    a_in_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'hF000_0000 + 32'(i);
      check("a_stream_in_ready", 64'(a_in_ready), 64'd1);
      if (a_in_ready) push_a(a_in_data, 4'hF, 1'b0);
      @(negedge clk);
      check("a_stream_tvalid", 64'(a_tvalid), 64'd1);
    end
    a_in_valid = 1'b0;
    drain_a();
    check("a_pkt_count", 64'(a_pkt_count), 64'd2);

    // Drive pkt_count up to 0xFFFF with single-beat packets, then wrap
    a_in_last = 1'b1;
    sent = 0;
    cyc  = 0;
    while (sent < 65533 && cyc < 65700) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(sent);
      if (a_in_ready) begin
        push_a(a_in_data, 4'hF, 1'b1);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    a_in_valid = 1'b0;
    check("wrap_sent", 64'(sent), 64'd65533);
    drain_a();
    check("pkt_count_max", 64'(a_pkt_count), 64'hFFFF);
    a_in_valid = 1'b1;
    a_in_data  = 32'h5A5A_5A5A;
    check("wrap_in_ready", 64'(a_in_ready), 64'd1);
    if (a_in_ready) push_a(a_in_data, 4'hF, 1'b1);
    @(negedge clk);
    a_in_valid = 1'b0;
    drain_a();
    check("pkt_count_wrap", 64'(a_pkt_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
